fm_sb_capture: RTL

FM_SB_CAPTURE -- requirements
Module: fm_sb_capture

---
 rtl/fm_sb_capture_if.sv | 33 +++
 rtl/fm_sb_capture.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fm_sb_capture_if.sv
// Signal bundle for the spy-buffer capture block: monitored stream, control
// inputs, spy-buffer write port and capture status.
interface fm_sb_capture_if #(
  parameter int DW     = 256,
  parameter int SB_DW  = 256,
  parameter int ADDR_W = 10
);
  logic [DW-1:0]     fm_data;
  logic              fm_vld;
  logic [1:0]        pb_mode;
  logic              arm;
  logic              freeze_req;
  logic [ADDR_W-1:0] post_trig_cnt;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [SB_DW-1:0]  mem_wdata;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] trig_addr;
  logic              wrapped;
  logic              frozen;
  logic [1:0]        state;

  modport master (
    output fm_data, fm_vld, pb_mode, arm, freeze_req, post_trig_cnt,
    input  mem_we, mem_addr, mem_wdata, wr_ptr, trig_addr, wrapped, frozen, state
  );

  modport slave (
    input  fm_data, fm_vld, pb_mode, arm, freeze_req, post_trig_cnt,
    output mem_we, mem_addr, mem_wdata, wr_ptr, trig_addr, wrapped, frozen, state
  );
endinterface

// File: rtl/fm_sb_capture.sv
// Spy-buffer capture engine: records valid fm_data words into a circular
// buffer, then freezes a programmable number of words after a trigger.
module fm_sb_capture #(
  parameter int DW     = 256,
  parameter int SB_DW  = 256,
  parameter int ADDR_W = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  fm_sb_capture_if.slave cap_if
);

  if (((SB_DW % 32) != 0) || (SB_DW > DW)) begin : g_bad_sb_dw
    $fatal(1, "fm_sb_capture: SB_DW must be a multiple of 32 and <= DW");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_POST   = 2'b10,
    ST_FROZEN = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic              wrapped_q, wrapped_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [SB_DW-1:0]  mem_wdata_q, mem_wdata_d;
  logic              wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      trig_addr_q <= '0;
      post_cnt_q  <= '0;
      wrapped_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_addr_q <= trig_addr_d;
      post_cnt_q  <= post_cnt_d;
      wrapped_q   <= wrapped_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    trig_addr_d = trig_addr_q;
    post_cnt_d  = post_cnt_q;
    wrapped_d   = wrapped_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_en       = 1'b0;

    // Any playback mode owns the buffer: drop to IDLE and suppress this cycle's write.
    if (cap_if.pb_mode != 2'b00) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_FROZEN: begin
          if (cap_if.arm) begin
            state_d   = ST_RUN;
            wr_ptr_d  = '0;
            wrapped_d = 1'b0;
          end
        end
        ST_RUN: begin
          wr_en = cap_if.fm_vld;
          if (cap_if.freeze_req) begin
            trig_addr_d = wr_ptr_q;
            post_cnt_d  = cap_if.post_trig_cnt;
            state_d     = (cap_if.post_trig_cnt == '0) ? ST_FROZEN : ST_POST;
          end
        end
        ST_POST: begin
          if (cap_if.fm_vld) begin
            wr_en      = 1'b1;
            post_cnt_d = post_cnt_q - 1'b1;
            if (post_cnt_q <= 1) begin
              state_d = ST_FROZEN;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (wr_en) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = wr_ptr_q;
      mem_wdata_d = cap_if.fm_data[SB_DW-1:0];
      wr_ptr_d    = wr_ptr_q + 1'b1;
      if (wr_ptr_q == {ADDR_W{1'b1}}) begin
        wrapped_d = 1'b1;
      end
    end
  end

  assign cap_if.mem_we    = mem_we_q;
  assign cap_if.mem_addr  = mem_addr_q;
  assign cap_if.mem_wdata = mem_wdata_q;
  assign cap_if.wr_ptr    = wr_ptr_q;
  assign cap_if.trig_addr = trig_addr_q;
  assign cap_if.wrapped   = wrapped_q;
  assign cap_if.frozen    = (state_q == ST_FROZEN);
  assign cap_if.state     = state_q;

endmodule
